// File: rtl/edit_field_ctrl_if.sv
// Button/level inputs and field-edit outputs of edit_field_ctrl, grouped as one bundle.
// master = stimulus/button side, slave = the controller.
interface edit_field_ctrl_if #(
    parameter int unsigned NUM_FIELDS = 6
);
    logic                  edit_sw;
    logic                  btn_up;
    logic                  btn_down;
    logic                  btn_left;
    logic                  btn_right;
    logic [NUM_FIELDS-1:0] en_field;
    logic                  aum;
    logic                  dism;
    logic [2:0]            sel;
    logic                  editing;
    logic                  blink;

    modport master (
        output edit_sw, btn_up, btn_down, btn_left, btn_right,
        input  en_field, aum, dism, sel, editing, blink
    );

    modport slave (
        input  edit_sw, btn_up, btn_down, btn_left, btn_right,
        output en_field, aum, dism, sel, editing, blink
    );
endinterface

// File: rtl/edit_field_ctrl.sv
// Time/date field editor: selects a counter with left/right and pulses it with up/down.
// Optional auto-repeat while a step button is held is enabled by macro EDIT_AUTO_REPEAT_EN.
module edit_field_ctrl #(
    parameter int unsigned NUM_FIELDS = 6,
    parameter int unsigned HOLD_CYC   = 50_000_000,
    parameter int unsigned RPT_CYC    = 10_000_000,
    parameter int unsigned BLINK_CYC  = 25_000_000
) (
    input  logic              clk,
    input  logic              reset,
    edit_field_ctrl_if.slave  bus
);

    localparam int unsigned SEL_W   = 3;
    localparam int unsigned MAX_HR  = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
    localparam int unsigned MAX_CYC = (MAX_HR > BLINK_CYC) ? MAX_HR : BLINK_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_FIELDS - 1);

`ifdef EDIT_AUTO_REPEAT_EN
    typedef enum logic [2:0] {S_IDLE, S_EDIT, S_STEP, S_HOLD, S_RPT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EDIT, S_STEP} state_t;
`endif

    state_t                r_state;
    logic [SEL_W-1:0]      r_sel;
    logic [NUM_FIELDS-1:0] r_en;
    logic                  r_aum;
    logic                  r_dism;
    logic                  r_editing;
    logic                  r_blink;
    logic [CNT_W-1:0]      r_blink_cnt;
    logic                  r_up_q;
    logic                  r_dn_q;
    logic                  r_lt_q;
    logic                  r_rt_q;
`ifdef EDIT_AUTO_REPEAT_EN
    logic                  r_dir;
    logic [CNT_W-1:0]      r_rep_cnt;
    logic                  w_held;
`endif

    logic             w_up_e;
    logic             w_dn_e;
    logic             w_lt_e;
    logic             w_rt_e;
    logic [SEL_W-1:0] w_sel_inc;
    logic [SEL_W-1:0] w_sel_dec;

    // Rising edges against last cycle's registered level: a held button edges once.
    assign w_up_e = bus.btn_up    & ~r_up_q;
    assign w_dn_e = bus.btn_down  & ~r_dn_q;
    assign w_lt_e = bus.btn_left  & ~r_lt_q;
    assign w_rt_e = bus.btn_right & ~r_rt_q;

    assign w_sel_inc = (r_sel == SEL_MAX) ? '0 : r_sel + SEL_W'(1);
    assign w_sel_dec = (r_sel == '0) ? SEL_MAX : r_sel - SEL_W'(1);

`ifdef EDIT_AUTO_REPEAT_EN
    // Only the button that started the sequence keeps it alive.
    assign w_held = r_dir ? bus.btn_down : bus.btn_up;
`endif

    function automatic logic [NUM_FIELDS-1:0] f_onehot(input logic [SEL_W-1:0] s);
        logic [NUM_FIELDS-1:0] one;
        one = {{(NUM_FIELDS-1){1'b0}}, 1'b1};
        return one << s;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_en        <= '0;
            r_aum       <= 1'b0;
            r_dism      <= 1'b0;
            r_editing   <= 1'b0;
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
            r_up_q      <= 1'b0;
            r_dn_q      <= 1'b0;
            r_lt_q      <= 1'b0;
            r_rt_q      <= 1'b0;
`ifdef EDIT_AUTO_REPEAT_EN
            r_dir       <= 1'b0;
            r_rep_cnt   <= '0;
`endif
        end else begin
            r_up_q <= bus.btn_up;
            r_dn_q <= bus.btn_down;
            r_lt_q <= bus.btn_left;
            r_rt_q <= bus.btn_right;
            r_aum  <= 1'b0;
            r_dism <= 1'b0;

            if (!bus.edit_sw) begin
                r_state     <= S_IDLE;
                r_sel       <= '0;
                r_en        <= '0;
                r_editing   <= 1'b0;
                r_blink     <= 1'b1;
                r_blink_cnt <= '0;
`ifdef EDIT_AUTO_REPEAT_EN
                r_rep_cnt   <= '0;
`endif
            end else begin
                // Free-running blink; the states below restart it on entry and on each pulse.
                if (r_blink_cnt >= CNT_W'(BLINK_CYC - 1)) begin
                    r_blink     <= ~r_blink;
                    r_blink_cnt <= '0;
                end else begin
                    r_blink_cnt <= r_blink_cnt + CNT_W'(1);
                end

                case (r_state)
                    S_IDLE: begin
                        r_state     <= S_EDIT;
                        r_sel       <= '0;
                        r_en        <= f_onehot('0);
                        r_editing   <= 1'b1;
                        r_blink     <= 1'b1;
                        r_blink_cnt <= '0;
                    end
                    S_EDIT: begin
                        if (w_up_e ^ w_dn_e) begin
                            r_state     <= S_STEP;
                            r_aum       <= w_up_e;
                            r_dism      <= w_dn_e;
                            r_blink     <= 1'b1;
                            r_blink_cnt <= '0;
`ifdef EDIT_AUTO_REPEAT_EN
                            r_dir       <= w_dn_e;
`endif
                        end else if (w_rt_e && !w_lt_e) begin
                            r_sel <= w_sel_inc;
                            r_en  <= f_onehot(w_sel_inc);
                        end else if (w_lt_e && !w_rt_e) begin
                            r_sel <= w_sel_dec;
                            r_en  <= f_onehot(w_sel_dec);
                        end
                    end
`ifdef EDIT_AUTO_REPEAT_EN
                    S_STEP: begin
                        // The STEP cycle counts as the first hold cycle.
                        if (w_held) begin
                            r_state   <= S_HOLD;
                            r_rep_cnt <= CNT_W'(1);
                        end else begin
                            r_state <= S_EDIT;
                        end
                    end
                    S_HOLD: begin
                        if (!w_held) begin
                            r_state <= S_EDIT;
                        end else if (r_rep_cnt >= CNT_W'(HOLD_CYC - 1)) begin
                            r_state   <= S_RPT;
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + CNT_W'(1);
                        end
                    end
                    S_RPT: begin
                        if (!w_held) begin
                            r_state <= S_EDIT;
                        end else if (r_rep_cnt >= CNT_W'(RPT_CYC - 1)) begin
                            r_rep_cnt   <= '0;
                            r_aum       <= ~r_dir;
                            r_dism      <= r_dir;
                            r_blink     <= 1'b1;
                            r_blink_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + CNT_W'(1);
                        end
                    end
`else
                    S_STEP: begin
                        r_state <= S_EDIT;
                    end
`endif
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.en_field = r_en;
    assign bus.aum      = r_aum;
    assign bus.dism     = r_dism;
    assign bus.sel      = r_sel;
    assign bus.editing  = r_editing;
    assign bus.blink    = r_blink;

endmodule

// File: tb/tb_edit_field_ctrl.sv
// Bench for edit_field_ctrl: directed scenarios plus random button traffic, checked
// every cycle against a press-timeline model; follows EDIT_AUTO_REPEAT_EN like the RTL.
`timescale 1ns/1ps
module tb_edit_field_ctrl;

    localparam int NF = 6;
    localparam int HC = 8;
    localparam int RC = 4;
    localparam int BC = 4;

    logic clk = 1'b0;
    logic reset;

    edit_field_ctrl_if #(.NUM_FIELDS(NF)) bus ();

    edit_field_ctrl #(
        .NUM_FIELDS (NF),
        .HOLD_CYC   (HC),
        .RPT_CYC    (RC),
        .BLINK_CYC  (BC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: editing flag, field index, active press (direction, cycles since press),
    // cycles since blink restart, and last sampled button levels.
    bit m_edit, m_active, m_dir, m_aum, m_dism;
    int m_sel, m_t, m_bc;
    bit p_up, p_dn, p_lt, p_rt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_edit = 0; m_active = 0; m_dir = 0; m_aum = 0; m_dism = 0;
        m_sel = 0; m_t = 0; m_bc = 0;
        p_up = 0; p_dn = 0; p_lt = 0; p_rt = 0;
    endtask

    task automatic model_edge();
        bit ue, de, le, re, pulse;
        ue = bus.btn_up & ~p_up;
        de = bus.btn_down & ~p_dn;
        le = bus.btn_left & ~p_lt;
        re = bus.btn_right & ~p_rt;
        p_up = bus.btn_up; p_dn = bus.btn_down; p_lt = bus.btn_left; p_rt = bus.btn_right;
        m_aum = 0; m_dism = 0; pulse = 0;
        if (!bus.edit_sw) begin
            m_edit = 0; m_sel = 0; m_active = 0; m_bc = 0;
        end else if (!m_edit) begin
            m_edit = 1; m_sel = 0; m_active = 0; m_bc = 0;
        end else begin
            if (m_active) begin
`ifdef EDIT_AUTO_REPEAT_EN
                m_t++;
                if (!(m_dir ? bus.btn_down : bus.btn_up)) m_active = 0;
                else if (m_t >= HC + RC && (m_t - HC) % RC == 0) pulse = 1;
`else
                m_active = 0;
`endif
            end else if (ue != de) begin
                m_active = 1; m_dir = de; m_t = 0; pulse = 1;
            end else if (re && !le) begin
                m_sel = (m_sel + 1) % NF;
            end else if (le && !re) begin
                m_sel = (m_sel + NF - 1) % NF;
            end
            if (pulse) begin
                m_aum = !m_dir; m_dism = m_dir; m_bc = 0;
            end else begin
                m_bc++;
            end
        end
    endtask

    function automatic logic [12:0] exp_vec();
        logic [5:0] en;
        logic       bl;
        en = m_edit ? (6'b000001 << m_sel) : 6'b000000;
        bl = m_edit ? (((m_bc / BC) % 2) == 0) : 1'b1;
        return {m_aum, m_dism, 3'(m_sel), en, m_edit, bl};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {bus.aum, bus.dism, bus.sel, bus.en_field, bus.editing, bus.blink};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("cycle", 32'(obs_vec()), 32'(exp_vec()));
    endtask

    int         pulses;
    logic [20:0] pos, exp_pos;
    logic [2:0] saved_sel;
    logic [5:0] one6;
    int         exp_sel_tbl [6] = '{1, 2, 3, 4, 5, 0};
    int         up_len, dn_len, lt_len, rt_len;

    initial begin
        reset = 1'b1;
        bus.edit_sw = 0; bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("reset_state", 32'(obs_vec()), 32'(13'b0_0_000_000000_0_1));
        @(negedge clk) reset = 1'b1;
        tick();
        tick();

        // Enter edit and walk right through every field
        bus.edit_sw = 1;
        tick();
        chk("enter_sel", 32'(bus.sel), 32'd0);
        chk("enter_en", 32'(bus.en_field), 32'h01);
        chk("enter_editing", 32'(bus.editing), 32'd1);
        one6 = 6'b000001;
        for (int k = 0; k < 6; k++) begin
            bus.btn_right = 1;
            tick();
            chk("right_sel", 32'(bus.sel), 32'(exp_sel_tbl[k]));
            chk("right_en", 32'(bus.en_field), 32'(one6 << exp_sel_tbl[k]));
            bus.btn_right = 0;
            tick();
        end

        // Left from field 0 wraps to the last field
        bus.btn_left = 1;
        tick();
        chk("left_wrap_sel", 32'(bus.sel), 32'd5);
        chk("left_wrap_en", 32'(bus.en_field), 32'h20);
        chk("left_no_pulse", 32'({bus.aum, bus.dism}), 32'd0);
        bus.btn_left = 0;
        tick();

        // Hold up: one pulse, or press + repeats at 12/16/20 with auto-repeat
        pulses = 0; pos = '0;
        bus.btn_up = 1;
        for (int i = 0; i <= 20; i++) begin
            tick();
            if (bus.aum) begin
                pulses++;
                pos[i] = 1'b1;
            end
        end
        bus.btn_up = 0;
        tick();
        tick();
`ifdef EDIT_AUTO_REPEAT_EN
        exp_pos = 21'd1 | (21'd1 << 12) | (21'd1 << 16) | (21'd1 << 20);
        chk("hold_pulse_count", 32'(pulses), 32'd4);
`else
        exp_pos = 21'd1;
        chk("hold_pulse_count", 32'(pulses), 32'd1);
`endif
        chk("hold_pulse_times", 32'(pos), 32'(exp_pos));

        // Simultaneous up/down edges give no pulse
        bus.btn_up = 1; bus.btn_down = 1;
        tick();
        chk("updn_no_pulse", 32'({bus.aum, bus.dism}), 32'd0);
        tick();
        chk("updn_stay_edit", 32'({bus.aum, bus.dism, bus.editing}), 32'd1);
        bus.btn_up = 0; bus.btn_down = 0;
        tick();

        // Down with a right edge: step wins, sel unchanged
        saved_sel = bus.sel;
        bus.btn_down = 1; bus.btn_right = 1;
        tick();
        chk("down_right_dism", 32'({bus.aum, bus.dism}), 32'd1);
        chk("down_right_sel", 32'(bus.sel), 32'(saved_sel));
        bus.btn_down = 0; bus.btn_right = 0;
        tick();
        tick();

        // Reset asserted mid-pulse with up held clears outputs without a clock
        bus.btn_up = 1;
        tick();
        chk("pre_reset_aum", 32'(bus.aum), 32'd1);
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_reset", 32'(obs_vec()), 32'(13'b0_0_000_000000_0_1));
        @(negedge clk) reset = 1'b1;
        bus.btn_up = 0;
        tick();
        tick();

        // Drop edit_sw during a held step (repeat phase when enabled)
        bus.btn_up = 1;
`ifdef EDIT_AUTO_REPEAT_EN
        for (int i = 0; i < 11; i++) tick();
`else
        tick();
        tick();
`endif
        bus.edit_sw = 0;
        tick();
        chk("drop_editing", 32'(bus.editing), 32'd0);
        chk("drop_en", 32'(bus.en_field), 32'd0);
        chk("drop_blink", 32'(bus.blink), 32'd1);
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.aum || bus.dism) pulses++;
        end
        chk("drop_no_pulse", 32'(pulses), 32'd0);
        bus.btn_up = 0;
        tick();

        // Random button traffic against the model
        bus.edit_sw = 1;
        up_len = 0; dn_len = 0; lt_len = 0; rt_len = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) == 0) bus.edit_sw = ~bus.edit_sw;
            if (up_len == 0) begin
                bus.btn_up = ($urandom_range(0, 2) == 0);
                up_len = $urandom_range(1, 26);
            end else up_len--;
            if (dn_len == 0) begin
                bus.btn_down = ($urandom_range(0, 2) == 0);
                dn_len = $urandom_range(1, 26);
            end else dn_len--;
            if (lt_len == 0) begin
                bus.btn_left = ($urandom_range(0, 3) == 0);
                lt_len = $urandom_range(1, 4);
            end else lt_len--;
            if (rt_len == 0) begin
                bus.btn_right = ($urandom_range(0, 3) == 0);
                rt_len = $urandom_range(1, 4);
            end else rt_len--;
            tick();
            chk("no_dual_pulse", 32'(bus.aum & bus.dism), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
